// File: rtl/tt_mask_idx_streamer.sv
// tt_mask_idx_streamer
// Streams 65-bit mask/index items to the load/store unit for masked strided
// and indexed vector memops, metered by a downstream credit counter.
// Optional build macro: TT_MASK_SKIP_EN -- indexed elements whose mask bit is
// 0 are scanned without emitting an item or consuming a credit.
//
// Handshake: o_item/o_last are meaningful only while o_valid is high. There is
// no ready; every o_valid cycle is one accepted item paid for by one credit,
// and the consumer hands each credit back with a single-cycle i_credit pulse.
// Index beats are accepted on any cycle where i_index_valid is high while the
// block is collecting indices; i_index_last is ignored without i_index_valid.
module tt_mask_idx_streamer #(
  parameter int VLEN         = 256,
  parameter int MASK_CREDITS = 2,
  parameter int IDX_SEGS     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic                       i_is_masked,
  input  logic                       i_is_indexed,
  input  logic [$clog2(VLEN+1)-1:0]  i_vl,
  input  logic [1:0]                 i_eew,
  input  logic [VLEN-1:0]            i_mask_data,
  input  logic [VLEN-1:0]            i_index_data,
  input  logic                       i_index_valid,
  input  logic                       i_index_last,
  input  logic                       i_credit,
  output logic [64:0]                o_item,
  output logic                       o_valid,
  output logic                       o_last,
  output logic                       o_busy,
  output logic                       o_err,
  output logic [1:0]                 o_dbg_state
);

  localparam int VLW = $clog2(VLEN + 1);
  localparam int PW  = $clog2(IDX_SEGS) + 1;
  localparam int CW  = $clog2(MASK_CREDITS + 1) + 1;
  localparam int IBW = IDX_SEGS * VLEN;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_IDX = 2'd1;
  localparam logic [1:0] ST_SEND     = 2'd2;

  logic [1:0]      state, state_n;
  logic [VLEN-1:0] mask_buf;
  logic [IBW-1:0]  idx_buf, idx_n, idx_shift;
  logic [PW-1:0]   wr_ptr, cap_ptr;
  logic [VLW-1:0]  count, vl_q, strided_cnt;
  logic [CW-1:0]   credits, credit_sum, credits_n;
  logic [1:0]      eew_q;
  logic            is_idx_q;
  logic            err;

  logic            start_acc, op_go, idx_go;
  logic            cap, cap_ok, cap_drop, cap_last;
  logic            cred_ovf, skip_this, advance, issue, item_last, done;
  logic [63:0]     idx_elem;
  logic [64:0]     item;
  logic [VLEN-1:0] vl_mask;

  // Control decode: op acceptance, index capture, credits and issue.
  always_comb begin
    start_acc   = (state == ST_IDLE) && i_start && !i_abort;
    op_go       = start_acc && (i_vl != '0) && (i_is_masked || i_is_indexed);
    idx_go      = op_go && i_is_indexed;
    cap         = i_index_valid && (idx_go || ((state == ST_WAIT_IDX) && !i_abort));
    cap_ptr     = idx_go ? '0 : wr_ptr;
    cap_ok      = cap && (cap_ptr < PW'(IDX_SEGS));
    cap_drop    = cap && !cap_ok;
    cap_last    = cap && i_index_last;
    strided_cnt = VLW'(({1'b0, i_vl} + (VLW+1)'(63)) >> 6);
    credit_sum  = credits + CW'(i_credit);
`ifdef TT_MASK_SKIP_EN
    skip_this   = is_idx_q && !mask_buf[0];
    // Bits above vl were cleared at start, so no remaining 1s means this
    // is the final emitted element.
    item_last   = (count == VLW'(1)) || (is_idx_q && (mask_buf[VLEN-1:1] == '0));
`else
    skip_this   = 1'b0;
    item_last   = (count == VLW'(1));
`endif
    advance     = (state == ST_SEND) && !i_abort && (skip_this || (credit_sum != '0));
    issue       = advance && !skip_this;
    done        = advance && ((count == VLW'(1)) || (issue && item_last));
    cred_ovf    = (credit_sum - CW'(issue)) > CW'(MASK_CREDITS);
    credits_n   = cred_ovf ? credits : (credit_sum - CW'(issue));
  end

  // Datapath: current index element, buffer shift by EEW, outgoing item.
  always_comb begin
    case (eew_q)
      2'd0:    idx_elem = {{56{idx_buf[7]}},  idx_buf[7:0]};
      2'd1:    idx_elem = {{48{idx_buf[15]}}, idx_buf[15:0]};
      2'd2:    idx_elem = {{32{idx_buf[31]}}, idx_buf[31:0]};
      default: idx_elem = idx_buf[63:0];
    endcase
    case (eew_q)
      2'd0:    idx_shift = idx_buf >> 8;
      2'd1:    idx_shift = idx_buf >> 16;
      2'd2:    idx_shift = idx_buf >> 32;
      default: idx_shift = idx_buf >> 64;
    endcase
    item = is_idx_q ? {mask_buf[0], idx_elem} : {1'b0, mask_buf[63:0]};
    vl_mask = '0;
    for (int i = 0; i < VLEN; i++) vl_mask[i] = (i < int'(i_vl));
  end

  // Index buffer next value: clear on a new indexed op, write beats, shift on advance.
  always_comb begin
    idx_n = idx_buf;
    if (idx_go) idx_n = '0;
    for (int s = 0; s < IDX_SEGS; s++) begin
      if (cap_ok && (cap_ptr == PW'(s))) idx_n[s*VLEN +: VLEN] = i_index_data;
    end
    if (advance && is_idx_q) idx_n = idx_shift;
  end

  // FSM next state; abort overrides everything but reset.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (op_go) state_n = (!i_is_indexed || cap_last) ? ST_SEND : ST_WAIT_IDX;
      ST_WAIT_IDX: if (cap_last) state_n = ST_SEND;
      ST_SEND:     if (done) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
    if (i_abort) state_n = ST_IDLE;
  end

  // FSM state, credit counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_IDLE;
      credits <= CW'(MASK_CREDITS);
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      credits <= credits_n;
      err     <= (start_acc ? 1'b0 : err) | cap_drop | cred_ovf;
    end
  end

  // Op context, mask/index buffers, element count and write pointer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mask_buf <= '0;
      idx_buf  <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      vl_q     <= '0;
      eew_q    <= '0;
      is_idx_q <= 1'b0;
    end else begin
      idx_buf <= idx_n;
      if (op_go) begin
        vl_q     <= i_vl;
        eew_q    <= i_eew;
        is_idx_q <= i_is_indexed;
        // Unmasked indexed ops tag every element active; bits past vl are
        // cleared so the skip logic can see where the last active one is.
        mask_buf <= i_is_indexed ? ((i_is_masked ? i_mask_data : '1) & vl_mask) : i_mask_data;
        count    <= i_is_indexed ? (cap_last ? i_vl : '0) : strided_cnt;
      end else if (advance) begin
        mask_buf <= is_idx_q ? (mask_buf >> 1) : (mask_buf >> 64);
        count    <= count - VLW'(1);
      end else if (cap_last) begin
        count    <= vl_q;
      end
      if (i_abort) count <= '0;
      if (i_abort)     wr_ptr <= '0;
      else if (idx_go) wr_ptr <= cap_ok ? PW'(1) : '0;
      else if (cap_ok) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Registered item outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_item  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      o_item  <= issue ? item : '0;
      o_valid <= issue;
      o_last  <= issue && item_last;
    end
  end

  assign o_busy      = (state != ST_IDLE);
  assign o_err       = err;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_tt_mask_idx_streamer.sv
// Bench for tt_mask_idx_streamer: directed scenarios plus randomized memops,
// each checked against a per-element reference model built from the op rules.
module tb_tt_mask_idx_streamer;

  localparam int VLEN         = 256;
  localparam int MASK_CREDITS = 2;
  localparam int IDX_SEGS     = 8;
  localparam int VLW          = $clog2(VLEN + 1);

  logic              i_clk = 1'b0;
  logic              i_reset, i_start, i_abort, i_is_masked, i_is_indexed;
  logic [VLW-1:0]    i_vl;
  logic [1:0]        i_eew;
  logic [VLEN-1:0]   i_mask_data, i_index_data;
  logic              i_index_valid, i_index_last, i_credit;
  logic [64:0]       o_item;
  logic              o_valid, o_last, o_busy, o_err;
  logic [1:0]        o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [64:0]     exp_q[$];
  logic            exp_last_q[$];
  logic [VLEN-1:0] beat_mem [0:15];
  int outstanding;
  int max_outstanding;
  int first_valid_cyc, last_valid_cyc, last_beat_cyc, max_gap, n_items;

  tt_mask_idx_streamer #(.VLEN(VLEN), .MASK_CREDITS(MASK_CREDITS), .IDX_SEGS(IDX_SEGS)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
    .i_is_masked(i_is_masked), .i_is_indexed(i_is_indexed), .i_vl(i_vl), .i_eew(i_eew),
    .i_mask_data(i_mask_data), .i_index_data(i_index_data), .i_index_valid(i_index_valid),
    .i_index_last(i_index_last), .i_credit(i_credit), .o_item(o_item), .o_valid(o_valid),
    .o_last(o_last), .o_busy(o_busy), .o_err(o_err), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    for (int w = 0; w < VLEN/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Expected items from the op definition: strided ops send consecutive 64-bit
  // mask chunks; indexed ops send element i = sign-extended bits [i*ew +: ew]
  // of the concatenated beats (beats past the buffer depth read as zero).
  task automatic build_expected(input logic masked, input logic indexed, input int vl,
                                input logic [1:0] eew, input logic [VLEN-1:0] mask,
                                input int nbeats);
    int ew, n, b, off;
    logic [63:0] raw;
    logic [VLEN-1:0] beat;
    logic mbit;
    exp_q.delete();
    exp_last_q.delete();
    if (vl == 0 || (!masked && !indexed)) return;
    if (!indexed) begin
      n = (vl + 63) / 64;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({1'b0, 64'(mask >> (64*k))});
        exp_last_q.push_back(k == n - 1);
      end
    end else begin
      ew = 8 << eew;
      for (int i = 0; i < vl; i++) begin
        b = (i * ew) / VLEN;
        off = (i * ew) % VLEN;
        beat = '0;
        if (b < nbeats && b < IDX_SEGS) beat = beat_mem[b];
        raw = 64'(beat >> off);
        if (ew < 64) begin
          if (raw[ew-1]) raw = raw | (~64'd0 << ew);
          else           raw = raw & ~(~64'd0 << ew);
        end
        mbit = masked ? mask[i] : 1'b1;
`ifdef TT_MASK_SKIP_EN
        if (!mbit) continue;
`endif
        exp_q.push_back({mbit, raw});
        exp_last_q.push_back(1'b0);
      end
      if (exp_q.size() > 0) exp_last_q[exp_last_q.size()-1] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    i_start = 0; i_abort = 0; i_is_masked = 0; i_is_indexed = 0; i_vl = '0; i_eew = '0;
    i_mask_data = '0; i_index_data = '0; i_index_valid = 0; i_index_last = 0; i_credit = 0;
  endtask

  task automatic return_credits();
    while (outstanding > 0) begin
      i_credit = 1;
      outstanding--;
      tick();
    end
    i_credit = 0;
    tick();
  endtask

  // Runs one memop against the items already queued in exp_q/exp_last_q.
  task automatic drive_and_check(input logic masked, input logic indexed, input int vl,
                                 input logic [1:0] eew, input logic [VLEN-1:0] mask,
                                 input int nbeats, input int credit_pct,
                                 input logic exp_err, input string name);
    int cyc, b;
    bit done;
    logic [64:0] e;
    logic el;
    n_items = 0; first_valid_cyc = -1; last_valid_cyc = -1; last_beat_cyc = -1;
    max_gap = 0; max_outstanding = outstanding;
    i_start = 1; i_is_masked = masked; i_is_indexed = indexed;
    i_vl = VLW'(vl); i_eew = eew; i_mask_data = mask;
    cyc = 0; b = 0; done = 0;
    while (!done && cyc < 4000) begin
      // drive this cycle's index beat and credit return
      i_index_data = rand_vec();
      if (indexed && b < nbeats && $urandom_range(0, 99) < 70) begin
        i_index_valid = 1;
        i_index_data  = beat_mem[b];
        i_index_last  = (b == nbeats - 1);
        if (b == nbeats - 1) last_beat_cyc = cyc;
        b++;
      end else begin
        i_index_valid = 0;
        i_index_last  = $urandom_range(0, 1);
      end
      if (outstanding > 0 && $urandom_range(0, 99) < credit_pct) begin
        i_credit = 1;
        outstanding--;
      end else begin
        i_credit = 0;
      end
      tick();
      cyc++;
      i_start = 0;
      i_mask_data = rand_vec();
      if (o_valid) begin
        n_items++;
        outstanding++;
        if (outstanding > max_outstanding) max_outstanding = outstanding;
        if (first_valid_cyc >= 0 && cyc - last_valid_cyc - 1 > max_gap) max_gap = cyc - last_valid_cyc - 1;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        last_valid_cyc = cyc;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra_item: got %h last=%b, no item expected", name, o_item, o_last);
        end else begin
          e  = exp_q.pop_front();
          el = exp_last_q.pop_front();
          if (o_item !== e || o_last !== el)
            $display("FAIL %s item%0d: got %h last=%b, expected %h last=%b", name, n_items-1, o_item, o_last, e, el);
          else n_pass++;
        end
      end
      if (exp_q.size() == 0 && !o_busy && (!indexed || b >= nbeats)) done = 1;
    end
    i_index_valid = 0; i_index_last = 0; i_credit = 0;
    n_checks++;
    if (!done) $display("FAIL %s completion: %0d items still expected after %0d cycles, busy=%b", name, exp_q.size(), cyc, o_busy);
    else n_pass++;
    n_checks++;
    if (o_err !== exp_err) $display("FAIL %s err: got %b, expected %b", name, o_err, exp_err);
    else n_pass++;
    n_checks++;
    if (max_outstanding > MASK_CREDITS) $display("FAIL %s credit_bound: %0d items outstanding, limit %0d", name, max_outstanding, MASK_CREDITS);
    else n_pass++;
    exp_q.delete();
    exp_last_q.delete();
    return_credits();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    i_reset = 1;
    outstanding = 0;
    repeat (3) tick();
    i_reset = 0;
    n_checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", o_valid); else n_pass++;
    n_checks++; if (o_last !== 1'b0) $display("FAIL reset_last: got %b, expected 0", o_last); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", o_busy); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL reset_err: got %b, expected 0", o_err); else n_pass++;
    n_checks++; if (o_item !== 65'd0) $display("FAIL reset_item: got %h, expected 0", o_item); else n_pass++;
    n_checks++; if (o_dbg_state !== 2'd0) $display("FAIL reset_state: got %0d, expected 0", o_dbg_state); else n_pass++;
    tick();
  endtask

  task automatic test_no_op();
    // vl==0 and unmasked strided ops never leave IDLE
    drive_and_check(1, 0, 0, 2'd0, rand_vec(), 0, 100, 1'b0, "vl_zero");
    drive_and_check(0, 0, 5, 2'd0, rand_vec(), 0, 100, 1'b0, "unmasked_strided");
  endtask

  task automatic test_strided_stall();
    int got;
    logic [64:0] e;
    logic el;
    exp_q.delete(); exp_last_q.delete();
    repeat (3) begin
      exp_q.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    end
    exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b0); exp_last_q.push_back(1'b1);
    i_start = 1; i_is_masked = 1; i_is_indexed = 0; i_vl = VLW'(130); i_mask_data = '1;
    tick();
    i_start = 0;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 10) i_credit = 1;
      if (c == 11) i_credit = 0;
      tick();
      if (o_valid) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL stall_item: unexpected item %h", o_item);
        else begin
          e = exp_q.pop_front(); el = exp_last_q.pop_front();
          if (o_item !== e || o_last !== el) $display("FAIL stall_item%0d: got %h last=%b, expected %h last=%b", got-1, o_item, o_last, e, el);
          else n_pass++;
        end
      end
      if (c == 9) begin
        n_checks++; if (got !== 2) $display("FAIL stall_count: got %0d items, expected 2", got); else n_pass++;
        n_checks++; if (o_busy !== 1'b1) $display("FAIL stall_busy: got %b, expected 1", o_busy); else n_pass++;
      end
    end
    n_checks++; if (got !== 3) $display("FAIL stall_total: got %0d items, expected 3", got); else n_pass++;
    n_checks++; if (o_busy !== 1'b0) $display("FAIL stall_done_busy: got %b, expected 0", o_busy); else n_pass++;
    exp_q.delete(); exp_last_q.delete();
    outstanding = 2;
    return_credits();
  endtask

  task automatic test_indexed_sign_ext();
    beat_mem[0] = '0;
    beat_mem[0][95:0] = {32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    exp_q.delete(); exp_last_q.delete();
    exp_q.push_back({1'b1, 64'hFFFF_FFFF_8000_0000}); exp_last_q.push_back(1'b0);
    exp_q.push_back({1'b1, 64'h0000_0000_0000_0005}); exp_last_q.push_back(1'b0);
    exp_q.push_back({1'b1, 64'hFFFF_FFFF_FFFF_FFFF}); exp_last_q.push_back(1'b1);
    drive_and_check(1, 1, 3, 2'd2, '1, 1, 100, 1'b0, "idx_eew32");
    n_checks++;
    if (first_valid_cyc !== last_beat_cyc + 2) $display("FAIL idx_latency: first item at %0d, last beat at %0d, expected +2", first_valid_cyc, last_beat_cyc);
    else n_pass++;
  endtask

  task automatic test_idx_overflow();
    logic [VLEN-1:0] m;
    for (int k = 0; k < 10; k++) beat_mem[k] = rand_vec();
    m = rand_vec();
    // eew=64, vl=40 needs 10 beats; the last two exceed the buffer
    build_expected(1, 1, 40, 2'd3, m, 10);
    drive_and_check(1, 1, 40, 2'd3, m, 10, 60, 1'b1, "idx_overflow");
    // a following start clears the sticky error
    m = rand_vec();
    build_expected(1, 0, 100, 2'd0, m, 0);
    drive_and_check(1, 0, 100, 2'd0, m, 0, 80, 1'b0, "err_cleared");
  endtask

  task automatic test_credit_overflow();
    int got;
    logic [64:0] e;
    logic el;
    logic [VLEN-1:0] m;
    i_credit = 1;
    tick();
    i_credit = 0;
    n_checks++; if (o_err !== 1'b1) $display("FAIL credit_ovf_err: got %b, expected 1", o_err); else n_pass++;
    m = rand_vec();
    build_expected(1, 0, 256, 2'd0, m, 0);
    i_start = 1; i_is_masked = 1; i_is_indexed = 0; i_vl = VLW'(256); i_mask_data = m;
    tick();
    i_start = 0;
    got = 0;
    for (int c = 0; c < 24; c++) begin
      i_credit = (c >= 10 && c < 14 && c % 2 == 0);
      tick();
      if (o_valid) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL ovf_item: unexpected item %h", o_item);
        else begin
          e = exp_q.pop_front(); el = exp_last_q.pop_front();
          if (o_item !== e || o_last !== el) $display("FAIL ovf_item%0d: got %h last=%b, expected %h last=%b", got-1, o_item, o_last, e, el);
          else n_pass++;
        end
      end
      if (c == 9) begin
        n_checks++; if (got !== 2) $display("FAIL ovf_counter: got %0d items on stored credits, expected 2", got); else n_pass++;
        n_checks++; if (o_err !== 1'b0) $display("FAIL ovf_err_clear: got %b, expected 0", o_err); else n_pass++;
      end
    end
    i_credit = 0;
    n_checks++; if (got !== 4 || o_busy !== 1'b0) $display("FAIL ovf_total: got %0d items busy=%b, expected 4 items busy=0", got, o_busy); else n_pass++;
    exp_q.delete(); exp_last_q.delete();
    outstanding = 2;
    return_credits();
  endtask

  task automatic test_abort();
    int got, late;
    logic [64:0] e;
    logic el;
    logic [VLEN-1:0] m;
    beat_mem[0] = rand_vec();
    build_expected(0, 1, 10, 2'd0, '0, 1);
    i_start = 1; i_is_masked = 0; i_is_indexed = 1; i_vl = VLW'(10); i_eew = 2'd0;
    i_index_valid = 1; i_index_last = 1; i_index_data = beat_mem[0];
    tick();
    i_start = 0; i_index_valid = 0; i_index_last = 0;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      i_credit = (c == 4 || c == 6);
      tick();
      if (o_valid) begin
        got++;
        n_checks++;
        e = exp_q.pop_front(); el = exp_last_q.pop_front();
        if (o_item !== e || o_last !== el) $display("FAIL abort_item%0d: got %h last=%b, expected %h last=%b", got-1, o_item, o_last, e, el);
        else n_pass++;
      end
    end
    i_credit = 0;
    n_checks++; if (got !== 4 || o_busy !== 1'b1) $display("FAIL abort_pre: got %0d items busy=%b, expected 4 busy=1", got, o_busy); else n_pass++;
    i_abort = 1;
    tick();
    i_abort = 0;
    late = o_valid;
    tick();
    n_checks++; if (o_busy !== 1'b0) $display("FAIL abort_busy: got %b, expected 0", o_busy); else n_pass++;
    for (int c = 0; c < 6; c++) begin
      i_credit = (c < 2);
      tick();
      late += o_valid;
    end
    i_credit = 0;
    n_checks++; if (late !== 0) $display("FAIL abort_items: got %0d items after abort, expected 0", late); else n_pass++;
    n_checks++; if (o_err !== 1'b0) $display("FAIL abort_credits: err=%b after returning 2 credits, expected 0", o_err); else n_pass++;
    exp_q.delete(); exp_last_q.delete();
    outstanding = 0;
    m = rand_vec();
    build_expected(1, 0, 200, 2'd0, m, 0);
    drive_and_check(1, 0, 200, 2'd0, m, 0, 70, 1'b0, "after_abort");
  endtask

  task automatic test_mask_skip();
    logic [VLEN-1:0] m;
    m = '0;
    m[3:0] = 4'b0101;
    beat_mem[0] = rand_vec();
    build_expected(1, 1, 4, 2'd0, m, 1);
    drive_and_check(1, 1, 4, 2'd0, m, 1, 100, 1'b0, "mask_skip");
`ifdef TT_MASK_SKIP_EN
    n_checks++; if (n_items !== 2) $display("FAIL skip_count: got %0d items, expected 2", n_items); else n_pass++;
`else
    n_checks++; if (n_items !== 4) $display("FAIL skip_count: got %0d items, expected 4", n_items); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    logic [VLEN-1:0] m;
    m = rand_vec();
    build_expected(1, 0, 256, 2'd0, m, 0);
    drive_and_check(1, 0, 256, 2'd0, m, 0, 100, 1'b0, "b2b");
    n_checks++; if (first_valid_cyc !== 2) $display("FAIL b2b_latency: first item at cycle %0d, expected 2", first_valid_cyc); else n_pass++;
    n_checks++; if (max_gap !== 0 || n_items !== 4) $display("FAIL b2b_gaps: gap=%0d items=%0d, expected 0 and 4", max_gap, n_items); else n_pass++;
  endtask

  task automatic test_random();
    logic indexed, masked;
    logic [1:0] eew;
    int vl, nbeats, ew, pct;
    logic [VLEN-1:0] m;
    for (int t = 0; t < 20; t++) begin
      indexed = $urandom_range(0, 1);
      masked  = indexed ? 1'($urandom_range(0, 1)) : 1'b1;
      eew     = 2'($urandom_range(0, 3));
      vl      = indexed ? $urandom_range(1, 96) : $urandom_range(1, VLEN);
      ew      = 8 << eew;
      nbeats  = indexed ? (vl * ew + VLEN - 1) / VLEN : 0;
      if (nbeats > IDX_SEGS) nbeats = IDX_SEGS;
      pct     = $urandom_range(30, 100);
      m       = rand_vec();
      for (int k = 0; k < IDX_SEGS; k++) beat_mem[k] = rand_vec();
      build_expected(masked, indexed, vl, eew, m, nbeats);
      drive_and_check(masked, indexed, vl, eew, m, nbeats, pct, 1'b0, "random");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_no_op();
    test_strided_stall();
    test_indexed_sign_ext();
    test_idx_overflow();
    test_credit_overflow();
    test_abort();
    test_mask_skip();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
